// File: rtl/amb_writeback.sv
`default_nettype none
// ============================================================================
// amb_writeback : one-beat stage register + commit (reg write / branch resolve)
// Rev 1.0
// ============================================================================
module amb_writeback #(
   parameter int DATA_W = 16,
   parameter int SHADOW = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        in_kind,
   input  logic [2:0]        in_dest,
   input  logic [DATA_W-1:0] in_result,
   input  logic              in_is_equal,
   input  logic [15:0]       in_pc,
   input  logic [7:0]        in_offset,
   input  logic [2:0]        rd_addr_a,
   input  logic [2:0]        rd_addr_b,
   output logic [DATA_W-1:0] rd_data_a,
   output logic [DATA_W-1:0] rd_data_b,
   output logic              pc_redirect_valid,
   output logic [15:0]       pc_redirect_target,
   output logic              flush,
   output logic [15:0]       commit_count,
   output logic [15:0]       squash_count
);

   localparam logic [1:0] c_KIND_NOP   = 2'b00;
   localparam logic [1:0] c_KIND_WRITE = 2'b01;
   localparam logic [1:0] c_KIND_BEQ   = 2'b10;
   localparam logic [1:0] c_KIND_BNE   = 2'b11;
   localparam logic [2:0] c_SHADOW     = 3'(SHADOW);

   typedef enum logic [0:0] {
      ST_RUN   = 1'b0,
      ST_DRAIN = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [2:0]          drain_cnt_q, drain_cnt_d;

   logic                stg_valid_q;
   logic [1:0]          stg_kind_q;
   logic [2:0]          stg_dest_q;
   logic [DATA_W-1:0]   stg_result_q;
   logic                stg_is_equal_q;
   logic [15:0]         stg_pc_q;
   logic [7:0]          stg_offset_q;

   logic [DATA_W-1:0]   regs_q [8];
   logic                redirect_valid_q;
   logic [15:0]         redirect_target_q;
   logic [15:0]         commit_count_q;
   logic [15:0]         squash_count_q;

   logic                w_accept;
   logic                w_commit_write;
   logic                w_taken;
   logic                w_squash;
   logic [15:0]         w_target;

   assign in_ready = !rst;

   always_comb begin
      w_accept       = in_valid && in_ready;
      w_commit_write = stg_valid_q && (stg_kind_q == c_KIND_WRITE);
      w_taken        = stg_valid_q &&
                       (((stg_kind_q == c_KIND_BEQ) &&  stg_is_equal_q) ||
                        ((stg_kind_q == c_KIND_BNE) && !stg_is_equal_q));
      // Window covers the commit edge plus the DRAIN edges before the last one.
      w_squash       = w_taken || ((state_q == ST_DRAIN) && (drain_cnt_q > 3'd1));
      w_target       = stg_pc_q + 16'd1 + {{8{stg_offset_q[7]}}, stg_offset_q};
   end

   always_comb begin
      state_d     = state_q;
      drain_cnt_d = drain_cnt_q;
      if (w_taken) begin
         state_d     = ST_DRAIN;
         drain_cnt_d = c_SHADOW;
      end else if (state_q == ST_DRAIN) begin
         drain_cnt_d = drain_cnt_q - 3'd1;
         if (drain_cnt_q == 3'd1) begin
            state_d = ST_RUN;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_RUN;
         drain_cnt_q <= 3'd0;
      end else begin
         state_q     <= state_d;
         drain_cnt_q <= drain_cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stg_valid_q       <= 1'b0;
         stg_kind_q        <= c_KIND_NOP;
         stg_dest_q        <= 3'd0;
         stg_result_q      <= '0;
         stg_is_equal_q    <= 1'b0;
         stg_pc_q          <= 16'd0;
         stg_offset_q      <= 8'd0;
         redirect_valid_q  <= 1'b0;
         redirect_target_q <= 16'd0;
         commit_count_q    <= 16'd0;
         squash_count_q    <= 16'd0;
         for (int i = 0; i < 8; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         stg_valid_q    <= w_accept && !w_squash;
         stg_kind_q     <= in_kind;
         stg_dest_q     <= in_dest;
         stg_result_q   <= in_result;
         stg_is_equal_q <= in_is_equal;
         stg_pc_q       <= in_pc;
         stg_offset_q   <= in_offset;

         redirect_valid_q <= w_taken;
         if (w_taken) begin
            redirect_target_q <= w_target;
         end
         if (stg_valid_q) begin
            commit_count_q <= commit_count_q + 16'd1;
         end
         if (w_accept && w_squash) begin
            squash_count_q <= squash_count_q + 16'd1;
         end
         if (w_commit_write && (stg_dest_q != 3'd0)) begin
            regs_q[stg_dest_q] <= stg_result_q;
         end
      end
   end

   // Pending stage write overrides the file so the consumer sees it a cycle early.
   always_comb begin
      if (rd_addr_a == 3'd0) begin
         rd_data_a = '0;
      end else if (w_commit_write && (stg_dest_q == rd_addr_a)) begin
         rd_data_a = stg_result_q;
      end else begin
         rd_data_a = regs_q[rd_addr_a];
      end
   end

   always_comb begin
      if (rd_addr_b == 3'd0) begin
         rd_data_b = '0;
      end else if (w_commit_write && (stg_dest_q == rd_addr_b)) begin
         rd_data_b = stg_result_q;
      end else begin
         rd_data_b = regs_q[rd_addr_b];
      end
   end

   assign pc_redirect_valid  = redirect_valid_q;
   assign pc_redirect_target = redirect_target_q;
   assign flush              = (state_q == ST_DRAIN);
   assign commit_count       = commit_count_q;
   assign squash_count       = squash_count_q;

endmodule
`default_nettype wire

// File: tb/tb_amb_writeback.sv
`default_nettype none
// ============================================================================
// tb_amb_writeback : directed stimulus, redirect scoreboard + direct checks
// Rev 1.0
// ============================================================================
module tb_amb_writeback;

   localparam int DATA_W = 16;
   localparam int SHADOW = 2;

   localparam logic [1:0] K_NOP = 2'b00;
   localparam logic [1:0] K_WR  = 2'b01;
   localparam logic [1:0] K_BEQ = 2'b10;
   localparam logic [1:0] K_BNE = 2'b11;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [1:0]        in_kind;
   logic [2:0]        in_dest;
   logic [DATA_W-1:0] in_result;
   logic              in_is_equal;
   logic [15:0]       in_pc;
   logic [7:0]        in_offset;
   logic [2:0]        rd_addr_a;
   logic [2:0]        rd_addr_b;
   logic [DATA_W-1:0] rd_data_a;
   logic [DATA_W-1:0] rd_data_b;
   logic              pc_redirect_valid;
   logic [15:0]       pc_redirect_target;
   logic              flush;
   logic [15:0]       commit_count;
   logic [15:0]       squash_count;

   int errors = 0;
   int checks = 0;
   logic [15:0] exp_q[$];

   amb_writeback #(.DATA_W(DATA_W), .SHADOW(SHADOW)) dut (
      .clk                (clk),
      .rst                (rst),
      .in_valid           (in_valid),
      .in_ready           (in_ready),
      .in_kind            (in_kind),
      .in_dest            (in_dest),
      .in_result          (in_result),
      .in_is_equal        (in_is_equal),
      .in_pc              (in_pc),
      .in_offset          (in_offset),
      .rd_addr_a          (rd_addr_a),
      .rd_addr_b          (rd_addr_b),
      .rd_data_a          (rd_data_a),
      .rd_data_b          (rd_data_b),
      .pc_redirect_valid  (pc_redirect_valid),
      .pc_redirect_target (pc_redirect_target),
      .flush              (flush),
      .commit_count       (commit_count),
      .squash_count       (squash_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Every redirect pulse must match the next queued target; any extra cycle is unexpected.
   initial begin
      forever begin
         @(negedge clk);
         if (pc_redirect_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL redirect_unexpected: got target 0x%0h expected no pulse",
                        pc_redirect_target);
            end else begin
               chk("redirect_target", {16'd0, pc_redirect_target}, {16'd0, exp_q.pop_front()});
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] k, input logic [2:0] d, input logic [15:0] r,
                        input logic eq, input logic [15:0] pc, input logic [7:0] off);
      in_valid    = 1'b1;
      in_kind     = k;
      in_dest     = d;
      in_result   = r;
      in_is_equal = eq;
      in_pc       = pc;
      in_offset   = off;
      step();
   endtask

   task automatic idle();
      in_valid = 1'b0;
      in_kind  = K_NOP;
      step();
   endtask

   task automatic chk_rd(input string name, input logic [2:0] a, input logic [15:0] exp);
      rd_addr_a = a;
      rd_addr_b = a;
      #1;
      chk({name, "_a"}, {16'd0, rd_data_a}, {16'd0, exp});
      chk({name, "_b"}, {16'd0, rd_data_b}, {16'd0, exp});
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0; in_kind = K_NOP; in_dest = 3'd0; in_result = 16'd0;
      in_is_equal = 1'b0; in_pc = 16'd0; in_offset = 8'd0;
      rd_addr_a = 3'd0; rd_addr_b = 3'd0;
      step();
      step();
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      rst = 1'b0;
      #1;
      chk("rst_in_ready_rel", {31'd0, in_ready}, 32'd1);
      chk("rst_flush", {31'd0, flush}, 32'd0);
      chk("rst_commit", {16'd0, commit_count}, 32'd0);
      chk("rst_squash", {16'd0, squash_count}, 32'd0);
      chk("rst_target", {16'd0, pc_redirect_target}, 32'd0);
      chk_rd("rst_r3", 3'd3, 16'h0000);

      // Write then read: forwarded the cycle after accept, then from the file
      drive(K_WR, 3'd3, 16'h1234, 1'b0, 16'h0000, 8'h00);
      chk_rd("fwd_r3", 3'd3, 16'h1234);
      drive(K_NOP, 3'd0, 16'h0000, 1'b0, 16'h0000, 8'h00);
      chk_rd("file_r3", 3'd3, 16'h1234);
      idle();
      chk("wr_commit", {16'd0, commit_count}, 32'd2);

      // Write to r0 is dropped but still counts
      drive(K_WR, 3'd0, 16'hFFFF, 1'b0, 16'h0000, 8'h00);
      chk_rd("r0_fwd", 3'd0, 16'h0000);
      idle();
      chk_rd("r0_file", 3'd0, 16'h0000);
      chk("r0_commit", {16'd0, commit_count}, 32'd3);

      // Taken BEQ with two back-to-back shadow writes: 0x10 + 1 - 4 = 0x0D
      exp_q.push_back(16'h000D);
      drive(K_BEQ, 3'd0, 16'h0000, 1'b1, 16'h0010, 8'hFC);
      drive(K_WR, 3'd1, 16'h0005, 1'b0, 16'h0000, 8'h00);
      chk("beq_flush1", {31'd0, flush}, 32'd1);
      drive(K_WR, 3'd2, 16'h0006, 1'b0, 16'h0000, 8'h00);
      chk("beq_flush2", {31'd0, flush}, 32'd1);
      idle();
      chk("beq_flush_end", {31'd0, flush}, 32'd0);
      chk("beq_squash", {16'd0, squash_count}, 32'd2);
      chk("beq_commit", {16'd0, commit_count}, 32'd4);
      chk_rd("beq_r1", 3'd1, 16'h0000);
      chk_rd("beq_r2", 3'd2, 16'h0000);

      // Not-taken BNE: no redirect, no flush
      drive(K_BNE, 3'd0, 16'h0000, 1'b1, 16'h0020, 8'h10);
      idle();
      chk("bne_flush", {31'd0, flush}, 32'd0);
      chk("bne_commit", {16'd0, commit_count}, 32'd5);

      // Target wrap: 0xFFFF + 1 + 0 = 0x0000
      exp_q.push_back(16'h0000);
      drive(K_BEQ, 3'd0, 16'h0000, 1'b1, 16'hFFFF, 8'h00);
      idle();
      chk("wrap_flush", {31'd0, flush}, 32'd1);
      idle();
      idle();
      chk("wrap_flush_end", {31'd0, flush}, 32'd0);
      chk("wrap_commit", {16'd0, commit_count}, 32'd6);

      // Branch accepted on the commit edge is squashed; beat on last drain edge survives
      exp_q.push_back(16'h0106);
      drive(K_BEQ, 3'd0, 16'h0000, 1'b1, 16'h0100, 8'h05);
      drive(K_BEQ, 3'd0, 16'h0000, 1'b1, 16'h0200, 8'h00);
      idle();
      drive(K_WR, 3'd4, 16'h4444, 1'b0, 16'h0000, 8'h00);
      chk("win_flush_end", {31'd0, flush}, 32'd0);
      idle();
      chk_rd("win_r4", 3'd4, 16'h4444);
      chk("win_squash", {16'd0, squash_count}, 32'd3);
      chk("win_commit", {16'd0, commit_count}, 32'd8);

      // Reset in the middle of the drain window
      exp_q.push_back(16'h0001);
      drive(K_BEQ, 3'd0, 16'h0000, 1'b1, 16'h0000, 8'h00);
      idle();
      chk("mid_flush", {31'd0, flush}, 32'd1);
      rst = 1'b1;
      in_valid = 1'b1; in_kind = K_WR; in_dest = 3'd5; in_result = 16'hBEEF;
      step();
      rst = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("mrst_flush", {31'd0, flush}, 32'd0);
      chk("mrst_commit", {16'd0, commit_count}, 32'd0);
      chk("mrst_squash", {16'd0, squash_count}, 32'd0);
      chk("mrst_redirect", {31'd0, pc_redirect_valid}, 32'd0);
      chk("mrst_target", {16'd0, pc_redirect_target}, 32'd0);
      chk_rd("mrst_r3", 3'd3, 16'h0000);
      chk_rd("mrst_r4", 3'd4, 16'h0000);
      drive(K_WR, 3'd5, 16'h5555, 1'b0, 16'h0000, 8'h00);
      idle();
      chk_rd("post_r5", 3'd5, 16'h5555);
      chk("post_commit", {16'd0, commit_count}, 32'd1);

      idle();
      idle();
      chk("sb_drained", exp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
